// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the 5-stage ARM pipeline
// hazard controller.
//   REG_ADDR_W   register-number width
//   XZR          zero register number (never forwards, never stalls)
//   FLAG_N..C    bit positions inside the {N,Z,V,C} flag vector
//   fwd_sel_e    operand-forwarding source select
//   stage_ctrl_t control bundle carried through the EX/MEM/WB shadow stages
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    REGFILE = 2'b00,
    MEM_RES = 2'b01,
    WB_RES  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rn;
    logic [REG_ADDR_W-1:0] rm;
    logic                  use_rn;
    logic                  use_rm;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  update_flag;
  } stage_ctrl_t;

  // A stage produces register r when it will write r; XZR is never produced.
  function automatic logic is_producer(input stage_ctrl_t s,
                                       input logic [REG_ADDR_W-1:0] r);
    return s.valid & s.reg_write & (s.rd == r) & (r != XZR);
  endfunction

  // EX operand source: the younger MEM result wins over the older WB result.
  function automatic fwd_sel_e ex_fwd_sel(input logic                  use_bit,
                                          input logic [REG_ADDR_W-1:0] r,
                                          input stage_ctrl_t           mem,
                                          input stage_ctrl_t           wb);
    if (!use_bit)                 return REGFILE;
    else if (is_producer(mem, r)) return MEM_RES;
    else if (is_producer(wb, r))  return WB_RES;
    else                          return REGFILE;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg: one shadow pipeline register holding a stage_ctrl_t.
//   clk, reset_n  rising-edge clock, asynchronous active-low reset
//   load          capture d at the clock edge
//   clear         load an all-zero bundle (bubble); wins over load
//   d / q         control bundle in / out
module ctrl_stage_reg
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        clear,
  input  stage_ctrl_t d,
  output stage_ctrl_t q
);

  // NOTE: sequential state uses non-blocking assignments so every stage
  // register samples its neighbour's pre-edge value, giving a true shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the IF/ID/EX/MEM/WB
// ARM datapath. Shadows the ID control bundle through EX/MEM/WB, detects
// load-use and branch-operand stalls, generates forwarding selects, owns the
// NZVC flag register, resolves B.LT in ID and keeps cycle/stall counters.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   id_valid, id_rn, id_rm            ID instruction and its source registers
//   id_use_rn, id_use_rm              source consumed by EX
//   id_br_uses_rb                     CBZ/BR consumes port-B value in ID
//   id_cond_br                        B.LT in ID
//   id_rd, id_reg_write, id_mem_read, id_update_flag  decoded controls
//   ex_flags_in                       ALU {N,Z,V,C} of the EX instruction
//   pc_write, ifid_write, id_bubble   stall controls (0/0/1 while stalled)
//   fwd_a, fwd_b                      EX operand select (00 rf, 01 MEM, 10 WB)
//   fwd_br                            ID branch operand select (00 rf, 01 MEM)
//   flags_q                           registered {N,Z,V,C}
//   br_lt_taken                       B.LT in ID taken this cycle
//   cycle_cnt, stall_cnt              wrapping performance counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rn,
  input  logic [ADDR_W-1:0] id_rm,
  input  logic              id_use_rn,
  input  logic              id_use_rm,
  input  logic              id_br_uses_rb,
  input  logic              id_cond_br,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_update_flag,
  input  logic [3:0]        ex_flags_in,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              id_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        fwd_br,
  output logic [3:0]        flags_q,
  output logic              br_lt_taken,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_ctrl_t id_bundle;
  stage_ctrl_t ex_q;
  stage_ctrl_t mem_q;
  stage_ctrl_t wb_q;

  logic       stall;
  logic       load_use;
  logic       br_ex_hazard;
  logic       br_mem_hazard;
  logic       ex_sets_flags;
  logic [3:0] eff_flags;

  always_comb begin
    id_bundle             = '0;
    id_bundle.valid       = id_valid;
    id_bundle.rn          = id_rn;
    id_bundle.rm          = id_rm;
    id_bundle.use_rn      = id_use_rn;
    id_bundle.use_rm      = id_use_rm;
    id_bundle.rd          = id_rd;
    id_bundle.reg_write   = id_reg_write;
    id_bundle.mem_read    = id_mem_read;
    id_bundle.update_flag = id_update_flag;
  end

  // ---------------------------------------------------------------------
  // Shadow stages. A stall turns the instruction entering EX into a bubble
  // while ID itself is held by pc_write/ifid_write.
  // ---------------------------------------------------------------------
  ctrl_stage_reg u_ex_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (1'b1),
    .clear   (stall),
    .d       (id_bundle),
    .q       (ex_q)
  );

  ctrl_stage_reg u_mem_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (1'b1),
    .clear   (1'b0),
    .d       (ex_q),
    .q       (mem_q)
  );

  ctrl_stage_reg u_wb_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (1'b1),
    .clear   (1'b0),
    .d       (mem_q),
    .q       (wb_q)
  );

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    load_use      = 1'b0;
    br_ex_hazard  = 1'b0;
    br_mem_hazard = 1'b0;

    // Load result is not available until after MEM, so an EX load feeding
    // the next instruction's EX stage costs one bubble.
    if (ex_q.mem_read) begin
      load_use = (id_use_rn & is_producer(ex_q, id_rn)) |
                 (id_use_rm & is_producer(ex_q, id_rm));
    end

    // CBZ/BR read their operand in ID, one stage earlier than EX consumers:
    // any EX producer is too late, and a MEM load is still too late.
    if (id_br_uses_rb) begin
      br_ex_hazard  = is_producer(ex_q, id_rm);
      br_mem_hazard = is_producer(mem_q, id_rm) & mem_q.mem_read;
    end

    stall = id_valid & (load_use | br_ex_hazard | br_mem_hazard);
  end

  always_comb begin
    pc_write   = ~stall;
    ifid_write = ~stall;
    id_bubble  = stall;
  end

  // ---------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------
  always_comb begin
    fwd_a  = ex_fwd_sel(ex_q.use_rn, ex_q.rn, mem_q, wb_q);
    fwd_b  = ex_fwd_sel(ex_q.use_rm, ex_q.rm, mem_q, wb_q);
    fwd_br = REGFILE;
    // The register file writes through, so a WB producer needs no bypass.
    if (id_br_uses_rb && is_producer(mem_q, id_rm) && !mem_q.mem_read) begin
      fwd_br = MEM_RES;
    end
  end

  // ---------------------------------------------------------------------
  // Flags and B.LT resolution
  // ---------------------------------------------------------------------
  always_comb begin
    ex_sets_flags = ex_q.valid & ex_q.update_flag;
    // A flag-setter directly ahead of B.LT is still in EX: bypass its flags.
    eff_flags     = ex_sets_flags ? ex_flags_in : flags_q;
    br_lt_taken   = id_valid & id_cond_br &
                    (eff_flags[FLAG_N] ^ eff_flags[FLAG_V]) & ~stall;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else if (ex_sets_flags) begin
      flags_q <= ex_flags_in;
    end
  end

  // ---------------------------------------------------------------------
  // Performance counters (wrap naturally)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (stall) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench for pipe_hazard_ctrl. Each task drives
// a short instruction sequence into ID and compares the controller outputs
// against hand-derived values. A second instance with a 3-bit counter width
// exercises counter wrap.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        id_use_rn, id_use_rm, id_br_uses_rb, id_cond_br;
  logic        id_reg_write, id_mem_read, id_update_flag;
  logic [3:0]  ex_flags_in;
  logic        pc_write, ifid_write, id_bubble, br_lt_taken;
  logic [1:0]  fwd_a, fwd_b, fwd_br;
  logic [3:0]  flags_q;
  logic [31:0] cycle_cnt, stall_cnt;

  logic        w3_pc_write, w3_ifid_write, w3_id_bubble, w3_br_lt_taken;
  logic [1:0]  w3_fwd_a, w3_fwd_b, w3_fwd_br;
  logic [3:0]  w3_flags_q;
  logic [2:0]  w3_cycle_cnt, w3_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_br_uses_rb(id_br_uses_rb), .id_cond_br(id_cond_br), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_update_flag(id_update_flag), .ex_flags_in(ex_flags_in),
    .pc_write(pc_write), .ifid_write(ifid_write), .id_bubble(id_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_br(fwd_br), .flags_q(flags_q),
    .br_lt_taken(br_lt_taken), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.ADDR_W(5), .CNT_W(3)) dut_w3 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_br_uses_rb(id_br_uses_rb), .id_cond_br(id_cond_br), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_update_flag(id_update_flag), .ex_flags_in(ex_flags_in),
    .pc_write(w3_pc_write), .ifid_write(w3_ifid_write), .id_bubble(w3_id_bubble),
    .fwd_a(w3_fwd_a), .fwd_b(w3_fwd_b), .fwd_br(w3_fwd_br), .flags_q(w3_flags_q),
    .br_lt_taken(w3_br_lt_taken), .cycle_cnt(w3_cycle_cnt), .stall_cnt(w3_stall_cnt)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // after that settle, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                        input logic urn, input logic urm, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic uf,
                        input logic brb, input logic cb);
    id_valid       = v;
    id_rn          = rn;
    id_rm          = rm;
    id_use_rn      = urn;
    id_use_rm      = urm;
    id_rd          = rd;
    id_reg_write   = rw;
    id_mem_read    = mr;
    id_update_flag = uf;
    id_br_uses_rb  = brb;
    id_cond_br     = cb;
    #1;
  endtask

  task automatic set_nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset is released 1 unit after an edge, so the first counted edge
  // follows.
  task automatic do_reset();
    reset_n     = 1'b0;
    ex_flags_in = 4'b0000;
    set_nop();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({pc_write, ifid_write, id_bubble, br_lt_taken} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=1100", {pc_write, ifid_write, id_bubble, br_lt_taken});
    end
    total++;
    if ({fwd_a, fwd_b, fwd_br} !== 6'b000000) begin
      bad++;
      $display("FAIL reset_fwd got=%b exp=000000", {fwd_a, fwd_b, fwd_br});
    end
    total++;
    if (flags_q !== 4'b0000 || cycle_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_state flags=%b cycle=%0d stall=%0d exp 0000/0/0",
               flags_q, cycle_cnt, stall_cnt);
    end
  endtask

  // ADDS X1,X2,X3 ; SUBS X4,X1,X5 ; ADD X7,X8,X9
  task automatic test_ex_forward();
    do_reset();
    set_id(1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 1, 0, 0);
    tick();
    set_id(1, 5'd1, 5'd5, 1, 1, 5'd4, 1, 0, 1, 0, 0);
    tick();
    set_id(1, 5'd8, 5'd9, 1, 1, 5'd7, 1, 0, 0, 0, 0);
    total++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
      bad++;
      $display("FAIL fwd_mem_a got=%b/%b exp=01/00", fwd_a, fwd_b);
    end
    tick();
    set_nop();
    total++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      bad++;
      $display("FAIL fwd_unrelated got=%b/%b exp=00/00", fwd_a, fwd_b);
    end
    // ADD X1 ; ADD X1 ; ADD X2,X1,X1 -> MEM beats WB for both operands.
    tick();
    set_id(1, 5'd5, 5'd6, 1, 1, 5'd1, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 5'd5, 5'd6, 1, 1, 5'd1, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 5'd1, 5'd1, 1, 1, 5'd2, 1, 0, 0, 0, 0);
    tick();
    set_nop();
    total++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
      bad++;
      $display("FAIL fwd_priority got=%b/%b exp=01/01", fwd_a, fwd_b);
    end
    // ADD X1 ; instruction naming X1 on both ports but using neither.
    tick();
    set_id(1, 5'd5, 5'd6, 1, 1, 5'd1, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 5'd1, 5'd1, 0, 0, 5'd2, 1, 0, 0, 0, 0);
    tick();
    set_nop();
    total++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      bad++;
      $display("FAIL fwd_use_masked got=%b/%b exp=00/00", fwd_a, fwd_b);
    end
  endtask

  // LDUR X3,[X0] ; ADD X6,X3,X7
  task automatic test_load_use();
    do_reset();
    set_id(1, 5'd0, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0, 0);
    tick();
    set_id(1, 5'd3, 5'd7, 1, 1, 5'd6, 1, 0, 0, 0, 0);
    total++;
    if ({pc_write, ifid_write, id_bubble} !== 3'b001 || stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL lu_stall got=%b stall_cnt=%0d exp=001 0",
               {pc_write, ifid_write, id_bubble}, stall_cnt);
    end
    tick();
    total++;
    if ({pc_write, ifid_write, id_bubble} !== 3'b110 || stall_cnt !== 32'd1) begin
      bad++;
      $display("FAIL lu_release got=%b stall_cnt=%0d exp=110 1",
               {pc_write, ifid_write, id_bubble}, stall_cnt);
    end
    tick();
    set_nop();
    total++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
      bad++;
      $display("FAIL lu_fwd_wb got=%b/%b exp=10/00", fwd_a, fwd_b);
    end
    total++;
    if (stall_cnt !== 32'd1 || cycle_cnt !== 32'd3) begin
      bad++;
      $display("FAIL lu_counters stall=%0d cycle=%0d exp 1/3", stall_cnt, cycle_cnt);
    end
  endtask

  // SUBS ; B.LT (bypass) ; ADD ; B.LT (flags_q) ; SUBS ; B.LT (not taken)
  task automatic test_flags();
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0, 1, 0, 0);
    tick();
    ex_flags_in = 4'b1000;
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1);
    total++;
    if (br_lt_taken !== 1'b1 || flags_q !== 4'b0000) begin
      bad++;
      $display("FAIL blt_bypass taken=%b flags_q=%b exp 1/0000", br_lt_taken, flags_q);
    end
    tick();
    total++;
    if (flags_q !== 4'b1000) begin
      bad++;
      $display("FAIL flags_capture got=%b exp=1000", flags_q);
    end
    ex_flags_in = 4'b0000;
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1);
    total++;
    if (br_lt_taken !== 1'b1 || flags_q !== 4'b1000) begin
      bad++;
      $display("FAIL blt_held taken=%b flags_q=%b exp 1/1000", br_lt_taken, flags_q);
    end
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0, 1, 0, 0);
    tick();
    ex_flags_in = 4'b1010;
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1);
    total++;
    if (br_lt_taken !== 1'b0) begin
      bad++;
      $display("FAIL blt_n_eq_v got=%b exp=0", br_lt_taken);
    end
    tick();
    ex_flags_in = 4'b0000;
    set_nop();
    total++;
    if (flags_q !== 4'b1010) begin
      bad++;
      $display("FAIL flags_second got=%b exp=1010", flags_q);
    end
  endtask

  // ADDI X4,X4,#1 ; CBZ X4  then  LDUR X4 ; CBZ X4
  task automatic test_cbz();
    do_reset();
    set_id(1, 5'd4, 5'd0, 1, 0, 5'd4, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 5'd0, 5'd4, 0, 0, 5'd0, 0, 0, 0, 1, 0);
    total++;
    if ({pc_write, id_bubble} !== 2'b01) begin
      bad++;
      $display("FAIL cbz_alu_stall got=%b exp=01", {pc_write, id_bubble});
    end
    tick();
    total++;
    if ({pc_write, id_bubble} !== 2'b10 || fwd_br !== 2'b01 || stall_cnt !== 32'd1) begin
      bad++;
      $display("FAIL cbz_alu_fwd ctl=%b fwd_br=%b stall=%0d exp 10/01/1",
               {pc_write, id_bubble}, fwd_br, stall_cnt);
    end
    set_id(1, 5'd0, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0, 0);
    tick();
    set_id(1, 5'd0, 5'd4, 0, 0, 5'd0, 0, 0, 0, 1, 0);
    total++;
    if (id_bubble !== 1'b1) begin
      bad++;
      $display("FAIL cbz_ld_stall1 got=%b exp=1", id_bubble);
    end
    tick();
    total++;
    if (id_bubble !== 1'b1 || fwd_br !== 2'b00 || stall_cnt !== 32'd2) begin
      bad++;
      $display("FAIL cbz_ld_stall2 bubble=%b fwd_br=%b stall=%0d exp 1/00/2",
               id_bubble, fwd_br, stall_cnt);
    end
    tick();
    total++;
    if (id_bubble !== 1'b0 || fwd_br !== 2'b00 || stall_cnt !== 32'd3) begin
      bad++;
      $display("FAIL cbz_ld_release bubble=%b fwd_br=%b stall=%0d exp 0/00/3",
               id_bubble, fwd_br, stall_cnt);
    end
    set_nop();
  endtask

  // ADDI X31,X1,#1 ; ADD X2,X31,X31
  task automatic test_xzr();
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd31, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 5'd31, 5'd31, 1, 1, 5'd2, 1, 0, 0, 0, 0);
    total++;
    if (id_bubble !== 1'b0) begin
      bad++;
      $display("FAIL xzr_no_stall got=%b exp=0", id_bubble);
    end
    tick();
    set_nop();
    total++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      bad++;
      $display("FAIL xzr_no_fwd got=%b/%b exp=00/00", fwd_a, fwd_b);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 9; i++) tick();
    total++;
    if (w3_cycle_cnt !== 3'd1 || cycle_cnt !== 32'd9) begin
      bad++;
      $display("FAIL cnt_wrap w3=%0d wide=%0d exp 1/9", w3_cycle_cnt, cycle_cnt);
    end
  endtask

  // SUBS (flags 0100) ; LDUR X3 ; ADD X6,X3 -> stall, then async reset.
  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0, 1, 0, 0);
    tick();
    ex_flags_in = 4'b0100;
    set_id(1, 5'd0, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0, 0);
    tick();
    ex_flags_in = 4'b0000;
    set_id(1, 5'd3, 5'd7, 1, 1, 5'd6, 1, 0, 0, 0, 0);
    total++;
    if (id_bubble !== 1'b1 || flags_q !== 4'b0100 || cycle_cnt !== 32'd2) begin
      bad++;
      $display("FAIL rst_pre bubble=%b flags=%b cycle=%0d exp 1/0100/2",
               id_bubble, flags_q, cycle_cnt);
    end
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if ({pc_write, ifid_write, id_bubble} !== 3'b110 || flags_q !== 4'b0000 ||
        cycle_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL rst_async ctl=%b flags=%b cycle=%0d stall=%0d exp 110/0000/0/0",
               {pc_write, ifid_write, id_bubble}, flags_q, cycle_cnt, stall_cnt);
    end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ex_forward();
    test_load_use();
    test_flags();
    test_cbz();
    test_xzr();
    test_counter_wrap();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage (IF/ID/EX/MEM/WB) ARM datapath.
- Takes the decoded control bundle of the instruction in ID and carries a shadow copy of it through EX/MEM/WB.
- Produces PC/IF-ID write enables, EX bubble insertion, operand forwarding selects and the ID-stage branch-operand select.
- Owns the architectural NZVC flag register and resolves B.LT in ID.
- Keeps cycle and stall performance counters.

## Interface
- ADDR_W, 5, register-number width
- CNT_W, 32, performance counter width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rn, id_rm  in  ADDR_W  read-port A/B register numbers (post Reg2Loc)
- id_use_rn, id_use_rm  in  1  port A/B value consumed by EX
- id_br_uses_rb  in  1  ID branch (CBZ, BR) consumes port-B value in ID
- id_cond_br  in  1  B.LT in ID
- id_rd  in  ADDR_W  destination register
- id_reg_write, id_mem_read, id_update_flag  in  1  decoded controls
- ex_flags_in  in  4  ALU {N,Z,V,C} of the EX instruction
- pc_write, ifid_write  out  1  0 holds PC / IF-ID register
- id_bubble  out  1  EX pipeline register loads a NOP
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM result, 10 WB result
- fwd_br  out  2  ID branch operand select: 00 regfile, 01 MEM result
- flags_q  out  4  registered {N,Z,V,C}
- br_lt_taken  out  1  B.LT in ID taken this cycle
- cycle_cnt, stall_cnt  out  CNT_W  performance counters

## Operation
Shadow stages:
- ex/mem/wb each hold valid, rn, rm, use_rn, use_rm, rd, reg_write, mem_read, update_flag.
- Each clock: wb←mem, mem←ex.
- ex←ID bundle when not stalled; otherwise ex.valid←0.

Producers:
- A stage is a producer of register r when valid & reg_write & rd==r & r!=31.
- XZR (31) never forwards and never stalls.

EX forwarding (per operand, using ex.rn/ex.rm):
- MEM producer → 01.
- Else WB producer → 10.
- Else → 00.
- MEM has priority over WB (youngest wins).
- Forced to 00 when the matching use bit is 0.

Stall:
- A stall is raised when id_valid and any of the following holds:
  - (a) Load-use: ex producer with mem_read matches an ID source whose use bit is set.
  - (b) id_br_uses_rb and EX is a producer of id_rm.
  - (c) id_br_uses_rb and MEM is a producer of id_rm with mem_read.
- During a stall: pc_write=0, ifid_write=0, id_bubble=1.

Branch operand (fwd_br):
- 01 when MEM is a non-load producer of id_rm and id_br_uses_rb; else 00.
- Regfile is write-through, so a WB producer needs no forwarding.

Flags:
- flags_q ← ex_flags_in at the clock edge when ex.valid & ex.update_flag.
- Effective flags = ex_flags_in if ex.valid & ex.update_flag, else flags_q.
- br_lt_taken = id_valid & id_cond_br & (effN ^ effV) & ~stall.

Counters:
- cycle_cnt +1 every cycle.
- stall_cnt +1 each cycle the stall is asserted.
- Both wrap modulo 2^CNT_W.

## Timing
Reset (asynchronous, on reset_n low):
- All shadow valids 0, flags_q 0000, counters 0.
- pc_write=1, ifid_write=1, id_bubble=0, fwd_a/fwd_b/fwd_br=00, br_lt_taken=0.
- reset_n low mid-stall drops the stall immediately; no state survives.

Combinational outputs (same cycle):
- Control outputs (pc_write, ifid_write, id_bubble, fwd_a, fwd_b, fwd_br, br_lt_taken) follow current inputs and shadow state.
- flags_q and counters are registered.

Stall duration:
- Load-use: exactly 1 cycle.
- CBZ/BR after ALU producer: 1 cycle.
- CBZ/BR after LDUR: 2 cycles (EX case, then MEM-load case).

B.LT:
- B.LT directly after SUBS/ADDS uses ex_flags_in in the same cycle; no stall.
- A non-flag-setting instruction between them leaves flags_q unchanged.

## Structure
- Package pipe_ctrl_pkg contains:
  - fwd_sel_e (REGFILE, MEM_RES, WB_RES)
  - stage_ctrl_t struct (shadow fields)
  - flag index constants FLAG_N/Z/V/C
  - XZR = 31
- Sub-module ctrl_stage_reg: async-reset register for one stage_ctrl_t with load/clear inputs, instantiated for ex, mem, wb.

## Test plan
- ADDS X1,X2,X3 then SUBS X4,X1,X5 → in SUBS EX cycle fwd_a=01, fwd_b=00; next cycle no forwarding for X1 from an unrelated instruction.
- LDUR X3,[X0] then ADD X6,X3,X7 → one cycle pc_write=0, ifid_write=0, id_bubble=1, stall_cnt 0→1; ADD then in EX with fwd_a=10.
- SUBS with ex_flags_in=1000 (N=1,V=0), B.LT next → br_lt_taken=1 that cycle while flags_q=0000; flags_q=1000 after the edge.
- ADDI X4,X4,#1 then CBZ X4 → 1 stall cycle, then fwd_br=01, stall_cnt=1; LDUR X4 then CBZ X4 → 2 stall cycles, then fwd_br=00.
- ADDI X31,X1,#1 then ADD X2,X31,X31 → fwd_a=fwd_b=00, no stall.
- Drive load-use stall, pull reset_n low mid-cycle → pc_write=1, id_bubble=0, counters=0, flags_q=0000 immediately, before the next clock.
